// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for an external combinational ALU.
// Optional overflow counter output: define ALU_ARBITER_OVCNT_EN.
module alu_arbiter #(
  parameter int nIO = 8,
  parameter int OPW = 3
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_req0_valid,
  output logic           o_req0_ready,
  input  logic [nIO-1:0] i_req0_a,
  input  logic [nIO-1:0] i_req0_b,
  input  logic [OPW-1:0] i_req0_op,
  input  logic           i_req1_valid,
  output logic           o_req1_ready,
  input  logic [nIO-1:0] i_req1_a,
  input  logic [nIO-1:0] i_req1_b,
  input  logic [OPW-1:0] i_req1_op,
  output logic           o_rsp0_valid,
  input  logic           i_rsp0_ready,
  output logic           o_rsp1_valid,
  input  logic           i_rsp1_ready,
  output logic [nIO-1:0] o_rsp_z,
  output logic           o_rsp_ov,
  output logic [nIO-1:0] o_alu_a,
  output logic [nIO-1:0] o_alu_b,
  output logic [OPW-1:0] o_alu_op,
  input  logic [nIO-1:0] i_alu_z,
  input  logic           i_alu_ov
`ifdef ALU_ARBITER_OVCNT_EN
  ,
  output logic [7:0]     o_ov_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last;
  logic           r_gnt;
  logic [nIO-1:0] r_a;
  logic [nIO-1:0] r_b;
  logic [OPW-1:0] r_op;
  logic [nIO-1:0] r_z;
  logic           r_ov;

  logic           w_gnt;
  logic           w_req0_ready;
  logic           w_req1_ready;
  logic           w_acc;
  logic           w_rsp_hs;
  logic [nIO-1:0] w_sel_a;
  logic [nIO-1:0] w_sel_b;
  logic [OPW-1:0] w_sel_op;

  // On contention the requester not served last wins.
  assign w_gnt = (i_req0_valid && i_req1_valid)
               ? ~r_last : i_req1_valid;

  assign w_sel_a  = w_gnt ? i_req1_a  : i_req0_a;
  assign w_sel_b  = w_gnt ? i_req1_b  : i_req0_b;
  assign w_sel_op = w_gnt ? i_req1_op : i_req0_op;

  assign w_acc    = w_req0_ready | w_req1_ready;
  assign w_rsp_hs = (r_state == S_RESP) &&
                    (r_gnt ? i_rsp1_ready
                           : i_rsp0_ready);

  always_comb begin
    w_next       = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_rst_n) begin
          w_req0_ready = i_req0_valid & ~w_gnt;
          w_req1_ready = i_req1_valid &  w_gnt;
        end
        if (w_req0_ready || w_req1_ready)
          w_next = S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (w_rsp_hs)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_z     <= '0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_gnt <= w_gnt;
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_op  <= w_sel_op;
      end
      if (r_state == S_EXEC) begin
        r_z  <= i_alu_z;
        r_ov <= i_alu_ov;
      end
      if (w_rsp_hs)
        r_last <= r_gnt;
    end
  end

`ifdef ALU_ARBITER_OVCNT_EN
  logic [7:0] r_ov_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_ov_cnt <= 8'd0;
    else if (w_rsp_hs && r_ov &&
             r_ov_cnt != 8'hFF)
      r_ov_cnt <= r_ov_cnt + 8'd1;
  end

  assign o_ov_cnt = r_ov_cnt;
`endif

  assign o_req0_ready = w_req0_ready;
  assign o_req1_ready = w_req1_ready;
  assign o_rsp0_valid = (r_state == S_RESP) & ~r_gnt;
  assign o_rsp1_valid = (r_state == S_RESP) &  r_gnt;
  assign o_rsp_z      = r_z;
  assign o_rsp_ov     = r_ov;
  assign o_alu_a      = r_a;
  assign o_alu_b      = r_b;
  assign o_alu_op     = r_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus
// scoreboard, with contention, backpressure and reset cases.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       v0, v1;
  logic       rdy0, rdy1;
  logic [7:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;
  logic       rv0, rv1;
  logic       rr0, rr1;
  logic [7:0] rsp_z;
  logic       rsp_ov;
  logic [7:0] alu_a, alu_b, alu_z;
  logic [2:0] alu_op;
  logic       alu_ov;
`ifdef ALU_ARBITER_OVCNT_EN
  logic [7:0] ov_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int rsp_cnt0 = 0;
  int rsp_cnt1 = 0;

  alu_arbiter #(.nIO(8), .OPW(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (v0),
    .o_req0_ready (rdy0),
    .i_req0_a     (a0),
    .i_req0_b     (b0),
    .i_req0_op    (op0),
    .i_req1_valid (v1),
    .o_req1_ready (rdy1),
    .i_req1_a     (a1),
    .i_req1_b     (b1),
    .i_req1_op    (op1),
    .o_rsp0_valid (rv0),
    .i_rsp0_ready (rr0),
    .o_rsp1_valid (rv1),
    .i_rsp1_ready (rr1),
    .o_rsp_z      (rsp_z),
    .o_rsp_ov     (rsp_ov),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_z      (alu_z),
    .i_alu_ov     (alu_ov)
`ifdef ALU_ARBITER_OVCNT_EN
    ,
    .o_ov_cnt     (ov_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [8:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    logic [7:0] z;
    logic       ov;
    z  = 8'd0;
    ov = 1'b0;
    case (op)
      3'd0: begin
        z  = a + b;
        ov = (a[7] == b[7]) && (z[7] != a[7]);
      end
      3'd1: begin
        z  = a - b;
        ov = (a[7] != b[7]) && (z[7] != a[7]);
      end
      3'd2: z = a & b;
      3'd3: z = a | b;
      3'd4: z = a ^ b;
      default: z = 8'd0;
    endcase
    return {ov, z};
  endfunction

  always_comb {alu_ov, alu_z} = alu_f(alu_a, alu_b, alu_op);

  typedef struct {
    bit         id;
    logic [7:0] z;
    logic       ov;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    logic [8:0] r;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rdy0 || rdy1) begin
        tests++;
        if (rdy0 && rdy1) begin
          fails++;
          $display("FAIL ready_excl: got both, want one");
        end
      end
      if (rdy0 && v0) begin
        r = alu_f(a0, b0, op0);
        e.id = 1'b0; e.z = r[7:0]; e.ov = r[8];
        sb.push_back(e);
      end
      if (rdy1 && v1) begin
        r = alu_f(a1, b1, op1);
        e.id = 1'b1; e.z = r[7:0]; e.ov = r[8];
        sb.push_back(e);
      end
      if ((rv0 && rr0) || (rv1 && rr1)) begin
        tests++;
        if (rv0) rsp_cnt0++;
        else     rsp_cnt1++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_pop: response with empty queue");
        end else begin
          e = sb.pop_front();
          if (e.id !== rv1 || e.z !== rsp_z ||
              e.ov !== rsp_ov) begin
            fails++;
            $display("FAIL sb_rsp: got id=%0d z=%h ov=%0d, want id=%0d z=%h ov=%0d",
                     rv1, rsp_z, rsp_ov, e.id, e.z, e.ov);
          end
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(input bit id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == 0 && rdy0) || (id == 1 && rdy1)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    v0 = 0; v1 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] z;
    logic       ov;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit ok;
    int lat;
    @(posedge clk); #1;
    if (v.id == 0) begin
      v0 = 1; a0 = v.a; b0 = v.b; op0 = v.op;
    end else begin
      v1 = 1; a1 = v.a; b1 = v.b; op1 = v.op;
    end
    wait_rdy(v.id, ok);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(v.id ? rv1 : rv0) && lat < 20);
    chk("latency", lat, 2);
    chk("rsp_z", {24'd0, rsp_z}, {24'd0, v.z});
    chk("rsp_ov", {31'd0, rsp_ov}, {31'd0, v.ov});
    @(posedge clk); #1;
  endtask

  vec_t vt[8];

  initial begin
    bit         ok;
    logic [7:0] z0;
    int         c0, c1;

    vt[0] = '{0, 8'd5,   8'd3,   3'd0, 8'd8,   1'b0};
    vt[1] = '{1, 8'd100, 8'd50,  3'd0, 8'h96,  1'b1};
    vt[2] = '{0, 8'h80,  8'hFF,  3'd0, 8'h7F,  1'b1};
    vt[3] = '{1, 8'd10,  8'd20,  3'd1, 8'hF6,  1'b0};
    vt[4] = '{0, 8'h80,  8'h01,  3'd1, 8'h7F,  1'b1};
    vt[5] = '{1, 8'hF0,  8'h3C,  3'd2, 8'h30,  1'b0};
    vt[6] = '{0, 8'hAA,  8'hFF,  3'd4, 8'h55,  1'b0};
    vt[7] = '{1, 8'd127, 8'd0,   3'd0, 8'd127, 1'b0};

    rst_n = 0;
    v0 = 0; v1 = 0;
    a0 = 0; b0 = 0; op0 = 0;
    a1 = 0; b1 = 0; op1 = 0;
    rr0 = 1; rr1 = 1;
    do_reset();
    @(negedge clk);
    chk("reset_out",
        {7'd0, rv0, rv1, rdy0, rdy1, rsp_ov, rsp_z,
         alu_a, 2'd0, alu_op},
        32'd0);
`ifdef ALU_ARBITER_OVCNT_EN
    chk("ovcnt_reset", {24'd0, ov_cnt}, 32'd0);
`endif

    foreach (vt[i]) run_vec(vt[i]);
`ifdef ALU_ARBITER_OVCNT_EN
    chk("ovcnt_3", {24'd0, ov_cnt}, 32'd3);
`endif

    // Contention from a fresh reset.
    do_reset();
    c0 = rsp_cnt0; c1 = rsp_cnt1;
    a0 = 8'd1;  b0 = 8'd2;  op0 = 3'd0;
    a1 = 8'd60; b1 = 8'd70; op1 = 3'd0;
    v0 = 1; v1 = 1;
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rdy0 || rdy1) begin
          ok = 1;
          break;
        end
      end
      chk("cont_accept", {31'd0, ok}, 32'd1);
      chk("cont_grant", {31'd0, rdy1}, k % 2);
      @(posedge clk); #1;
    end
    v0 = 0; v1 = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("cont_cnt0", rsp_cnt0 - c0, 2);
    chk("cont_cnt1", rsp_cnt1 - c1, 2);

    // Response backpressure.
    @(posedge clk); #1;
    rr0 = 0;
    v0 = 1; a0 = 8'd7; b0 = 8'd9; op0 = 3'd0;
    wait_rdy(0, ok);
    @(posedge clk); #1;
    v0 = 0;
    v1 = 1; a1 = 8'd3; b1 = 8'd4; op1 = 3'd0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rv0) begin
        ok = 1;
        break;
      end
    end
    chk("bp_valid", {31'd0, ok}, 32'd1);
    z0 = rsp_z;
    chk("bp_z", {24'd0, z0}, 32'd16);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {22'd0, rv0, rdy1, z0},
          {22'd0, 1'b1, 1'b0, rsp_z});
      chk("bp_zstable", {24'd0, rsp_z}, {24'd0, z0});
    end
    @(posedge clk); #1;
    rr0 = 1;
    wait_rdy(1, ok);
    @(posedge clk); #1;
    v1 = 0;
    repeat (4) @(posedge clk);

    // Reset while in EXEC; requester 0 was served last.
    vt[0].id = 0;
    run_vec(vt[0]);
    @(posedge clk); #1;
    v0 = 1; a0 = 8'd33; b0 = 8'd44; op0 = 3'd0;
    wait_rdy(0, ok);
    @(posedge clk); #1;
    v0 = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out",
          {7'd0, rv0, rv1, rdy0, rdy1, rsp_ov, rsp_z,
           alu_a, 2'd0, alu_op},
          32'd0);
    end
`ifdef ALU_ARBITER_OVCNT_EN
    chk("ovcnt_rst", {24'd0, ov_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    a1 = 8'd2; b1 = 8'd2;
    v0 = 1; v1 = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy0 || rdy1) begin
        ok = 1;
        break;
      end
    end
    chk("rst_accept", {31'd0, ok}, 32'd1);
    chk("rst_grant0", {31'd0, rdy0}, 32'd1);
    @(posedge clk); #1;
    v0 = 0; v1 = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
